ra_pq_batch_ctl: RTL and testbench

Batch sort controller that drives the replace/dequeue-only register-array priority queue from the master side of its interface. It accepts a batch of up to CAPACITY key-value pairs on a valid/ready input stream and inserts each one with a replace operation. It then pads the queue, drains the batch in ascending key order onto a valid/ready output stream, and clears the queue for the next batch.

---
 rtl/pq_pkg.sv | 29 ++
 rtl/ra_pq_out_reg.sv | 30 +++
 rtl/ra_pq_batch_ctl.sv | 150 +++++++++++++++
 tb/tb_ra_pq_batch_ctl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the register-array priority queue and its batch controller.
package pq_pkg;

  localparam int unsigned PQ_CAPACITY = 8;
  localparam int unsigned KW = 16;
  localparam int unsigned VW = 16;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } kv_t;

  // All-ones and all-zeros keys are sentinels; real keys lie strictly between them.
  localparam logic [KW-1:0] KEYINF    = {KW{1'b1}};
  localparam logic [KW-1:0] KEYNEGINF = {KW{1'b0}};
  localparam logic [VW-1:0] VAL0      = {VW{1'b0}};

  typedef enum logic [1:0] {
    StClear,
    StFill,
    StPad,
    StDrain
  } ra_pq_batch_state_t;

  function automatic logic is_reserved(input logic [KW-1:0] key);
    return (key == KEYINF) || (key == KEYNEGINF);
  endfunction

endpackage

// File: rtl/ra_pq_out_reg.sv
// Registered output stage for the sorted stream: holds kv/last while stalled.
module ra_pq_out_reg
  import pq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  kv_t  kv,
  input  logic last,
  input  logic out_ready,
  output logic out_valid,
  output kv_t  out_kv,
  output logic out_last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_kv    <= {KEYINF, VAL0};
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_kv    <= kv;
      out_last  <= last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ra_pq_batch_ctl.sv
// Batch sort controller mastering a replace/dequeue-only priority queue.
// Optional RA_PQ_BATCH_CHECK_EN adds a sticky err for reserved keys and out-of-order output.
module ra_pq_batch_ctl
  import pq_pkg::*;
#(
  parameter int unsigned CAPACITY = ((PQ_CAPACITY + 1) / 2) * 2,
  parameter int unsigned CW       = $clog2(CAPACITY + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  kv_t  in_kv,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output kv_t  out_kv,
  output logic out_last,
  output logic pq_replace,
  output logic pq_deq,
  output kv_t  pq_kvi,
  input  kv_t  pq_kvo,
  input  logic pq_busy,
  output logic pq_clr,
  output logic err
);

  localparam logic [CW-1:0] CapW = CW'(CAPACITY);

  ra_pq_batch_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, nrep_q, nrep_d, rem_q, rem_d;
  logic load;
  logic in_rsvd;
  logic out_hs;

  assign in_rsvd = is_reserved(in_kv.key);
  assign out_hs  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    nrep_d     = nrep_q;
    rem_d      = rem_q;
    in_ready   = 1'b0;
    pq_clr     = 1'b0;
    pq_replace = 1'b0;
    pq_deq     = 1'b0;
    pq_kvi     = {KEYINF, VAL0};
    load       = 1'b0;
    unique case (state_q)
      StClear: begin
        pq_clr  = 1'b1;
        count_d = '0;
        nrep_d  = '0;
        state_d = StFill;
      end
      StFill: begin
        in_ready = !pq_busy && (count_q < CapW);
        if (in_valid && in_ready) begin
          // Sentinel keys would corrupt the ordering, so they are swallowed.
          if (!in_rsvd) begin
            pq_replace = 1'b1;
            pq_kvi     = in_kv;
            count_d    = count_q + 1'b1;
            nrep_d     = nrep_q + 1'b1;
          end
          if (in_last || (count_d == CapW)) begin
            state_d = (count_d == '0) ? StClear : StPad;
          end
        end
      end
      StPad: begin
        // Push KEYINF until every KEYNEGINF left by the clear has been evicted.
        if (nrep_q == CapW) begin
          state_d = StDrain;
          rem_d   = count_q;
        end else if (!pq_busy) begin
          pq_replace = 1'b1;
          nrep_d     = nrep_q + 1'b1;
        end
      end
      StDrain: begin
        if ((rem_q != '0) && !pq_busy && (!out_valid || out_ready)) begin
          load   = 1'b1;
          pq_deq = 1'b1;
          rem_d  = rem_q - 1'b1;
        end
        if (out_hs && out_last) begin
          state_d = StClear;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StClear;
      count_q <= '0;
      nrep_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      nrep_q  <= nrep_d;
      rem_q   <= rem_d;
    end
  end

  ra_pq_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .kv        (pq_kvo),
    .last      (rem_q == CW'(1)),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_kv    (out_kv),
    .out_last  (out_last)
  );

`ifdef RA_PQ_BATCH_CHECK_EN
  logic [KW-1:0] prev_key_q;
  logic          err_q;
  logic          rsvd_acc;

  assign rsvd_acc = in_valid && in_ready && in_rsvd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_key_q <= KEYNEGINF;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StClear) begin
        prev_key_q <= KEYNEGINF;
      end else if (out_hs) begin
        prev_key_q <= out_kv.key;
      end
      if (rsvd_acc || (out_hs && (out_kv.key < prev_key_q))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ra_pq_batch_ctl.sv
// Scoreboard bench for ra_pq_batch_ctl with a behavioural replace/dequeue priority queue.
module tb_ra_pq_batch_ctl;
  import pq_pkg::*;

  localparam int unsigned CAP = 8;

  typedef struct packed {
    kv_t  kv;
    logic last;
  } exp_t;
  typedef logic [15:0] karr_t [8];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic pq_replace, pq_deq, pq_busy, pq_clr, err;
  kv_t  in_kv, out_kv, pq_kvi, pq_kvo;

  always #5 clk = ~clk;

  ra_pq_batch_ctl #(.CAPACITY(CAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kv      (in_kv),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kv     (out_kv),
    .out_last   (out_last),
    .pq_replace (pq_replace),
    .pq_deq     (pq_deq),
    .pq_kvi     (pq_kvi),
    .pq_kvo     (pq_kvo),
    .pq_busy    (pq_busy),
    .pq_clr     (pq_clr),
    .err        (err)
  );

  // Behavioural queue: replace/deq overwrite the current minimum.
  kv_t q [CAP];
  int  min_idx;

  always_comb begin
    min_idx = 0;
    for (int i = 1; i < CAP; i++) if (q[i].key < q[min_idx].key) min_idx = i;
    pq_kvo = q[min_idx];
  end

  always @(posedge clk) begin
    if (pq_clr) begin
      for (int i = 0; i < CAP; i++) q[i] <= {KEYNEGINF, VAL0};
    end else if (pq_replace) begin
      q[min_idx] <= pq_kvi;
    end else if (pq_deq) begin
      q[min_idx] <= {KEYINF, VAL0};
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  exp_t sb[$];
  int   n_pop = 0, cyc = 0, first_cyc = 0, span = -1, pad_cnt = 0, viol = 0, stall_cnt = 0;
  bit   in_batch = 0, stalled = 0;
  exp_t held, e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops, stall hold, busy gating and strobe exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      stalled  = 0;
      in_batch = 0;
    end else begin
      if (pq_replace && pq_deq) viol++;
      if (pq_replace && !pq_busy && (pq_kvi.key == KEYINF)) pad_cnt++;
      if (pq_busy) begin
        check("busy_in_ready", in_ready, 0);
        check("busy_strobes", {pq_replace, pq_deq}, 0);
      end
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_kv", {out_kv, out_last}, held);
      end
      if (out_valid && !out_ready) begin
        check("stall_deq", pq_deq, 0);
        stalled = 1;
        stall_cnt++;
        held = {out_kv, out_last};
      end else begin
        stalled = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_out: got key %0h, expected no output", out_kv.key);
        end else begin
          e = sb.pop_front();
          check("out", {out_kv, out_last}, e);
          n_pop++;
          if (!in_batch) begin
            first_cyc = cyc;
            in_batch  = 1;
          end
          if (out_last) begin
            span     = cyc - first_cyc;
            in_batch = 0;
          end
        end
      end
    end
  end

  function automatic kv_t mk(input logic [15:0] k);
    return {k, k ^ 16'hA5A5};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [15:0] k, input bit last);
    bit acc = 0;
    int g = 0;
    in_valid = 1;
    in_kv    = mk(k);
    in_last  = last;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_timeout: in_ready for key %0h got 0, expected 1", k);
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic send_batch(input karr_t keys, input int n);
    for (int i = 0; i < n; i++) send_beat(keys[i], i == n - 1);
  endtask

  task automatic push_exp(input karr_t keys, input int n);
    for (int i = 0; i < n; i++) sb.push_back({mk(keys[i]), 1'(i == n - 1)});
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending outputs, expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [3:0] rdy_pat = 4'b1001;
  int         rdy_idx = 0;
  bit         rdy_mode = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode) begin
      out_ready = rdy_pat[rdy_idx % 4];
      rdy_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g;
    in_valid  = 0;
    in_kv     = '0;
    in_last   = 0;
    out_ready = 1;
    pq_busy   = 0;
    rst       = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_kv", out_kv, {KEYINF, VAL0});
    check("rst_in_ready", in_ready, 0);
    check("rst_pq_clr", pq_clr, 1);
    check("rst_strobes", {pq_replace, pq_deq}, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("clr_after_reset", pq_clr, 1);
    @(posedge clk);
    #1;

    // Full batch: no padding, back-to-back drain, then a clear pulse.
    pad_cnt = 0;
    push_exp('{1, 2, 3, 5, 6, 7, 8, 9}, 8);
    send_batch('{7, 3, 9, 1, 8, 2, 6, 5}, 8);
    wait_drain();
    @(negedge clk);
    #1;
    check("clr_after_full", pq_clr, 1);
    check("full_span", span, 7);
    check("full_pad", pad_cnt, 0);

    // Short batch: six KEYINF pads.
    pad_cnt = 0;
    push_exp('{2, 4, 0, 0, 0, 0, 0, 0}, 2);
    send_batch('{4, 2, 0, 0, 0, 0, 0, 0}, 2);
    wait_drain();
    check("short_pad", pad_cnt, 6);
    check("short_span", span, 1);

    // Downstream backpressure pattern 1,0,0,1.
    stall_cnt = 0;
    rdy_idx   = 0;
    rdy_mode  = 1;
    push_exp('{1, 4, 5, 0, 0, 0, 0, 0}, 3);
    send_batch('{5, 1, 4, 0, 0, 0, 0, 0}, 3);
    wait_drain();
    rdy_mode  = 0;
    out_ready = 1;
    check("stall_seen", stall_cnt != 0, 1);

    // Reserved key mid-batch is consumed and dropped.
    push_exp('{3, 6, 0, 0, 0, 0, 0, 0}, 2);
    send_batch('{6, 16'hFFFF, 3, 0, 0, 0, 0, 0}, 3);
    wait_drain();
`ifdef RA_PQ_BATCH_CHECK_EN
    check("err_reserved", err, 1);
`else
    check("err_reserved", err, 0);
`endif

    // Batch of only a reserved key returns straight to clear.
    send_beat(16'h0000, 1);
    @(negedge clk);
    check("clr_empty_batch", pq_clr, 1);
    @(posedge clk);
    #1;

    // Queue stall in fill and in drain.
    push_exp('{2, 4, 7, 9, 0, 0, 0, 0}, 4);
    fork
      send_batch('{9, 4, 7, 2, 0, 0, 0, 0}, 4);
      begin
        @(posedge clk);
        #1 pq_busy = 1;
        repeat (3) @(posedge clk);
        #1 pq_busy = 0;
      end
    join
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("busy_drain_start", out_valid, 1);
    @(posedge clk);
    #1 pq_busy = 1;
    repeat (3) @(posedge clk);
    #1 pq_busy = 0;
    wait_drain();

    // Reset after two of five outputs; then a fresh batch.
    push_exp('{1, 3, 5, 6, 8, 0, 0, 0}, 5);
    base = n_pop;
    send_batch('{8, 3, 6, 1, 5, 0, 0, 0}, 5);
    g = 0;
    while (n_pop < base + 2 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("pre_reset_outputs", n_pop - base, 2);
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_pq_clr", pq_clr, 1);
    check("reset_err", err, 0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("clr_after_mid_reset", pq_clr, 1);
    @(posedge clk);
    #1;
    push_exp('{10, 11, 0, 0, 0, 0, 0, 0}, 2);
    send_batch('{11, 10, 0, 0, 0, 0, 0, 0}, 2);
    wait_drain();

    repeat (3) @(posedge clk);
    check("protocol_viol", viol, 0);
    check("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
